// File: rtl/pipe_stage_skid.sv
// Valid/ready pipeline stage with a 2-entry skid buffer.
// Both ready and data paths are registered; flush and stall accounting included.
module pipe_stage_skid #(
  parameter int              DW     = 64,
  parameter logic [DW-1:0]   BUBBLE = '0,
  parameter int              CNT_W  = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [DW-1:0]    in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DW-1:0]    out_data,
  output logic [1:0]       occupancy,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam logic [1:0] EMPTY = 2'd0;
  localparam logic [1:0] BUSY  = 2'd1;
  localparam logic [1:0] FULL  = 2'd2;

  logic [1:0]    state, state_d;
  logic [DW-1:0] main_q, main_d;
  logic [DW-1:0] skid_q, skid_d;
  logic          rdy_q;
  logic          vld;
  logic          in_fire;
  logic          out_fire;

  assign vld      = (state != EMPTY);
  assign in_fire  = in_valid & rdy_q;
  assign out_fire = vld & out_ready;

  always_comb begin
    state_d = state;
    main_d  = main_q;
    skid_d  = skid_q;
    unique case (state)
      EMPTY: begin
        if (in_fire) begin
          state_d = BUSY;
          main_d  = in_data;
        end
      end
      BUSY: begin
        if (in_fire && out_fire) begin
          main_d = in_data;
        end else if (in_fire) begin
          state_d = FULL;
          skid_d  = in_data;
        end else if (out_fire) begin
          state_d = EMPTY;
          main_d  = BUBBLE;
        end
      end
      FULL: begin
        if (out_fire) begin
          state_d = BUSY;
          main_d  = skid_q;
          skid_d  = BUBBLE;
        end
      end
      default: begin
        state_d = EMPTY;
        main_d  = BUBBLE;
        skid_d  = BUBBLE;
      end
    endcase
    // flush discards held entries and any entry offered this cycle
    if (flush) begin
      state_d = EMPTY;
      main_d  = BUBBLE;
      skid_d  = BUBBLE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= EMPTY;
      main_q    <= BUBBLE;
      skid_q    <= BUBBLE;
      rdy_q     <= 1'b1;
      stall_cnt <= '0;
    end else begin
      state  <= state_d;
      main_q <= main_d;
      skid_q <= skid_d;
      rdy_q  <= (state_d != FULL);
      if (vld && !out_ready && (stall_cnt != '1))
        stall_cnt <= stall_cnt + 1'b1;
    end
  end

  assign in_ready  = rdy_q;
  assign out_valid = vld;
  assign out_data  = main_q;
  assign occupancy = state;

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Bench for pipe_stage_skid: directed vector table, corner sequences,
// and a random valid/ready run against a queue scoreboard.
module tb_pipe_stage_skid;

  localparam int DW    = 64;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [DW-1:0]    in_data;
  logic             out_valid;
  logic             out_ready;
  logic [DW-1:0]    out_data;
  logic [1:0]       occupancy;
  logic [CNT_W-1:0] stall_cnt;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  pipe_stage_skid #(
    .DW(DW),
    .BUBBLE(64'h0),
    .CNT_W(CNT_W)
  ) dut (
    .clk(clk),
    .reset(reset),
    .flush(flush),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data(in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
    .occupancy(occupancy),
    .stall_cnt(stall_cnt)
  );

  typedef struct {
    logic          rst;
    logic          fl;
    logic          iv;
    logic [DW-1:0] id;
    logic          ordy;
    logic          e_ov;
    logic [DW-1:0] e_od;
    logic          e_ir;
    logic [1:0]    e_occ;
    int            e_st;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic rst, logic fl, logic iv,
                              logic [DW-1:0] id, logic ordy,
                              logic e_ov, logic [DW-1:0] e_od,
                              logic e_ir, logic [1:0] e_occ, int e_st);
    vec_t v;
    v.rst = rst; v.fl = fl; v.iv = iv; v.id = id; v.ordy = ordy;
    v.e_ov = e_ov; v.e_od = e_od; v.e_ir = e_ir;
    v.e_occ = e_occ; v.e_st = e_st;
    return v;
  endfunction

  task automatic chk(string nm, logic [DW-1:0] act, logic [DW-1:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(logic rst, logic fl, logic iv,
                       logic [DW-1:0] id, logic ordy);
    @(negedge clk);
    reset = rst; flush = fl; in_valid = iv;
    in_data = id; out_ready = ordy;
  endtask

  task automatic apply(vec_t v, int k);
    drive(v.rst, v.fl, v.iv, v.id, v.ordy);
    @(posedge clk);
    #1;
    chk($sformatf("v%0d out_valid", k), out_valid, v.e_ov);
    chk($sformatf("v%0d out_data", k), out_data, v.e_od);
    chk($sformatf("v%0d in_ready", k), in_ready, v.e_ir);
    chk($sformatf("v%0d occupancy", k), occupancy, v.e_occ);
    chk($sformatf("v%0d stall_cnt", k), stall_cnt, v.e_st);
  endtask

  logic [DW-1:0] sb[$];

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0;
    in_data = '0; out_ready = 1'b0;

    // T1 reset (with junk data offered)
    tbl.push_back(mk(1, 0, 1, 64'hdead, 0, 0, 0, 1, 0, 0));
    // T2 streaming 1..8 then drain
    for (int i = 1; i <= 8; i++)
      tbl.push_back(mk(0, 0, 1, i, 1, 1, i, 1, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0, 1, 0, 0));
    // T3 back-pressure A,B,C then release
    tbl.push_back(mk(0, 0, 1, 'hA, 0, 1, 'hA, 1, 1, 0));
    tbl.push_back(mk(0, 0, 1, 'hB, 0, 1, 'hA, 0, 2, 1));
    tbl.push_back(mk(0, 0, 1, 'hC, 0, 1, 'hA, 0, 2, 2));
    tbl.push_back(mk(0, 0, 1, 'hC, 0, 1, 'hA, 0, 2, 3));
    tbl.push_back(mk(0, 0, 1, 'hC, 1, 1, 'hB, 1, 1, 3));
    tbl.push_back(mk(0, 0, 1, 'hC, 1, 1, 'hC, 1, 1, 3));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0, 1, 0, 3));
    // T4 fill, then flush while FULL with 0xD offered
    tbl.push_back(mk(0, 0, 1, 'h11, 0, 1, 'h11, 1, 1, 3));
    tbl.push_back(mk(0, 0, 1, 'h12, 0, 1, 'h11, 0, 2, 4));
    tbl.push_back(mk(0, 1, 1, 'hD, 0, 0, 0, 1, 0, 5));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0, 1, 0, 5));
    // flush coinciding with an out_fire empties the stage
    tbl.push_back(mk(0, 0, 1, 'h21, 1, 1, 'h21, 1, 1, 5));
    tbl.push_back(mk(0, 1, 0, 0, 1, 0, 0, 1, 0, 5));

    for (int k = 0; k < tbl.size(); k++)
      apply(tbl[k], k);

    // T5 stall saturation with one entry held
    apply(mk(0, 0, 1, 'h55, 0, 1, 'h55, 1, 1, 5), 100);
    for (int i = 1; i <= 20; i++) begin
      int e;
      e = (5 + i > 15) ? 15 : 5 + i;
      drive(0, 0, 0, 0, 0);
      @(posedge clk);
      #1;
      chk($sformatf("sat%0d stall_cnt", i), stall_cnt, e);
      chk($sformatf("sat%0d out_data", i), out_data, 64'h55);
    end
    // reset mid-transfer drops the held entry and clears the counter
    apply(mk(1, 0, 0, 0, 0, 0, 0, 1, 0, 0), 101);

    // T6 random traffic against a scoreboard
    begin
      logic [DW-1:0] seq;
      logic          ifire, ofire, rst_now, fl_now;
      seq = 64'h1000;
      for (int c = 0; c < 10000; c++) begin
        rst_now = (c == 5000);
        fl_now  = ($urandom_range(0, 199) == 0);
        drive(rst_now, fl_now, $urandom_range(0, 3) != 0, seq,
              $urandom_range(0, 2) != 0);
        #1;
        if (occupancy != sb.size()) begin
          chk($sformatf("rnd%0d occupancy", c), occupancy, sb.size());
        end else if (c % 50 == 0) begin
          chk($sformatf("rnd%0d occupancy", c), occupancy, sb.size());
        end
        ifire = in_valid & in_ready;
        ofire = out_valid & out_ready;
        if (ofire && !rst_now) begin
          if (sb.size() == 0)
            chk($sformatf("rnd%0d spurious", c), out_data, 64'hffff);
          else
            chk($sformatf("rnd%0d data", c), out_data, sb.pop_front());
        end
        if (rst_now || fl_now)
          sb.delete();
        else if (ifire)
          sb.push_back(seq);
        if (ifire)
          seq++;
        @(posedge clk);
      end
      drive(0, 0, 0, 0, 1);
      #1;
      chk("rnd final occupancy", occupancy, sb.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
